// File: rtl/raw10_unpacker_pkg.sv
// raw10_unpacker_pkg: shared CSI constants, FSM encoding and data-type helper.
package raw10_unpacker_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_LINE, ST_DRAIN} state_e;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam int GROUP_BYTES = 5;
    function automatic logic is_raw10(input logic [5:0] dt);
        return dt == DT_RAW10;
    endfunction
endpackage

// File: rtl/raw10_unpacker_if.sv
// raw10_unpacker_if: packet-layer byte stream in, unpacked pixel stream out.
interface raw10_unpacker_if #(
    parameter int ADDR_W = 25,
    parameter int X_W    = 12,
    parameter int Y_W    = 12
);
    logic              fs;
    logic              fe;
    logic              ls;
    logic [15:0]       word_cnt;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              pix_valid;
    logic [9:0]        pix_data;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;
    logic [ADDR_W-1:0] pix_addr;
    logic              frame_active;
    logic              line_done;
    logic              err_len;
    logic              err_trunc;
    modport slave (
        input  fs, fe, ls, word_cnt, byte_valid, byte_data,
        output pix_valid, pix_data, pix_x, pix_y, pix_addr, frame_active, line_done, err_len, err_trunc
    );
    modport master (
        output fs, fe, ls, word_cnt, byte_valid, byte_data,
        input  pix_valid, pix_data, pix_x, pix_y, pix_addr, frame_active, line_done, err_len, err_trunc
    );
endinterface

// File: rtl/raw10_group_shift.sv
// raw10_group_shift: collects four MSB bytes plus the LSB byte, then shifts out four 10-bit pixels.
module raw10_group_shift
    import raw10_unpacker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_clr_i,
    input  logic       out_clr_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       pix_valid_o,
    output logic [9:0] pix_data_o,
    output logic       last_o
);
    logic [2:0]  pos_q, pos_d, cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d, msb_q, msb_d;
    logic [7:0]  lsb_q, lsb_d;
    logic        load;
    assign load = byte_valid_i && pos_q == 3'(GROUP_BYTES - 1);
    // The LSB byte goes straight to the shifter so P0 appears the cycle after it.
    always_comb begin
        pos_d = (cap_clr_i || out_clr_i || load) ? 3'd0 : pos_q + 3'(byte_valid_i);
        cap_d = cap_q;
        if (out_clr_i) cap_d = '0;
        else if (byte_valid_i && !load) cap_d[{pos_q, 3'b000} +: 8] = byte_data_i;
        msb_d = {8'd0, msb_q[31:8]};
        lsb_d = {2'd0, lsb_q[7:2]};
        cnt_d = cnt_q - 3'(cnt_q != 3'd0);
        if (out_clr_i) begin
            msb_d = '0;
            lsb_d = '0;
            cnt_d = '0;
        end else if (load) begin
            msb_d = cap_q;
            lsb_d = byte_data_i;
            cnt_d = 3'd4;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
            cnt_q <= '0;
            cap_q <= '0;
            msb_q <= '0;
            lsb_q <= '0;
        end else begin
            pos_q <= pos_d;
            cnt_q <= cnt_d;
            cap_q <= cap_d;
            msb_q <= msb_d;
            lsb_q <= lsb_d;
        end
    end
    assign pix_valid_o = cnt_q != 3'd0;
    assign pix_data_o  = {msb_q[7:0], lsb_q[1:0]};
    assign last_o      = cnt_q <= 3'd1;
endmodule

// File: rtl/raw10_unpacker.sv
// raw10_unpacker: frame/line tracking around the RAW10 group shifter, with
// pixel coordinates, line-done pulses and sticky length/truncation errors.
module raw10_unpacker
    import raw10_unpacker_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int X_W    = 12,
    parameter int Y_W    = 12
) (
    input logic              byte_clk,
    input logic              reset,
    raw10_unpacker_if.slave  bus
);
    state_e            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d, bcnt_q, bcnt_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wc_q, wc_d;
    logic              fa_q, fa_d, ld_q, ld_d, el_q, el_d, et_q, et_d;
    logic              pv, last, out_clr, take;
    logic [9:0]        pdata;
    always_comb begin
        state_d = state_q;
        x_d     = x_q + X_W'(pv);
        addr_d  = addr_q + ADDR_W'(pv);
        y_d     = y_q;
        wc_d    = wc_q;
        bcnt_d  = bcnt_q;
        fa_d    = fa_q;
        ld_d    = 1'b0;
        el_d    = el_q;
        et_d    = et_q;
        out_clr = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.fs) begin
                    el_d = 1'b0;
                    et_d = 1'b0;
                end
            end
            ST_FRAME: begin
                if (!bus.fs && bus.fe) begin
                    state_d = ST_IDLE;
                    fa_d    = 1'b0;
                end else if (!bus.fs && bus.ls) begin
                    el_d = el_q | (bus.word_cnt % 16'd5 != 16'd0);
                    if (bus.word_cnt == 16'd0) begin
                        ld_d = 1'b1;
                        y_d  = y_q + Y_W'(1);
                    end else begin
                        state_d = ST_LINE;
                        wc_d    = bus.word_cnt;
                        bcnt_d  = '0;
                        x_d     = '0;
                    end
                end
            end
            default: begin
                if (bus.fs || bus.fe) begin
                    et_d    = 1'b1;
                    out_clr = 1'b1;
                    state_d = ST_IDLE;
                    fa_d    = 1'b0;
                end else if (state_q == ST_LINE) begin
                    if (bus.byte_valid) begin
                        take   = 1'b1;
                        bcnt_d = bcnt_q + X_W'(1);
                        if (16'(bcnt_d) == wc_q) state_d = ST_DRAIN;
                    end
                end else if (last) begin
                    ld_d    = 1'b1;
                    y_d     = y_q + Y_W'(1);
                    state_d = ST_FRAME;
                end
            end
        endcase
        // A frame start in any state restarts the frame; errors survive unless coming from IDLE.
        if (bus.fs) begin
            state_d = ST_FRAME;
            fa_d    = 1'b1;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end
    end
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            wc_q    <= '0;
            bcnt_q  <= '0;
            fa_q    <= 1'b0;
            ld_q    <= 1'b0;
            el_q    <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            bcnt_q  <= bcnt_d;
            fa_q    <= fa_d;
            ld_q    <= ld_d;
            el_q    <= el_d;
            et_q    <= et_d;
        end
    end
    raw10_group_shift u_shift (
        .clk          (byte_clk),
        .rst          (reset),
        .cap_clr_i    (state_q != ST_LINE),
        .out_clr_i    (out_clr),
        .byte_valid_i (take),
        .byte_data_i  (bus.byte_data),
        .pix_valid_o  (pv),
        .pix_data_o   (pdata),
        .last_o       (last)
    );
    assign bus.pix_valid    = pv;
    assign bus.pix_data     = pdata;
    assign bus.pix_x        = x_q;
    assign bus.pix_y        = y_q;
    assign bus.pix_addr     = addr_q;
    assign bus.frame_active = fa_q;
    assign bus.line_done    = ld_q;
    assign bus.err_len      = el_q;
    assign bus.err_trunc    = et_q;
endmodule

// File: doc/raw10_unpacker.md
RAW10_UNPACKER -- requirements
Module: raw10_unpacker

Interface
REQ-001 Parameter ADDR_W, default 25, width of pix_addr.
REQ-002 Parameter X_W, default 12, width of pix_x and line byte counter; Y_W, default 12, width of pix_y.
REQ-003 byte_clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 fs  input  1  frame-start pulse, from packet layer, one cycle.
REQ-006 fe  input  1  frame-end pulse, one cycle.
REQ-007 ls  input  1  RAW10 long-packet start pulse; qualifies word_cnt.
REQ-008 word_cnt  input  16  payload byte count of the packet flagged by ls.
REQ-009 byte_valid  input  1  byte_data holds a payload byte this cycle.
REQ-010 byte_data  input  8  payload byte, packet order.
REQ-011 pix_valid  output  1  pix_data, pix_x, pix_y, pix_addr valid.
REQ-012 pix_data  output  10  unpacked pixel.
REQ-013 pix_x / pix_y  output  X_W / Y_W  column / line index of the pixel.
REQ-014 pix_addr  output  ADDR_W  linear pixel index within frame.
REQ-015 frame_active  output  1  high from accepted fs to fe.
REQ-016 line_done  output  1  one-cycle pulse after the last pixel of a line.
REQ-017 err_len  output  1  sticky: word_cnt not a multiple of 5.
REQ-018 err_trunc  output  1  sticky: fe or fs arrived mid-line.

Function
REQ-019 FSM states IDLE, FRAME, LINE, DRAIN; IDLE on reset.
REQ-020 IDLE: fs -> FRAME, pix_y=0, pix_addr=0, frame_active=1, err_len/err_trunc cleared; all other inputs ignored.
REQ-021 FRAME: ls -> LINE, latch word_cnt, byte counter=0, pix_x=0; word_cnt==0 -> line_done next cycle, stay FRAME; fe -> IDLE, frame_active=0.
REQ-022 LINE: each byte_valid increments byte counter; bytes at group positions 0..3 stored as MSBs of P0..P3; position 4 is the LSB byte.
REQ-023 Pixel Pi = {MSB_i, lsb[2i+1:2i]}, i=0..3.
REQ-024 On the cycle after the 5th byte of a group is accepted, the group transfers to an output register; P0..P3 emitted on 4 consecutive cycles, pix_valid high each.
REQ-025 Back-to-back byte_valid (1 byte/cycle) SHALL sustain without loss; next group never completes before the previous drains.
REQ-026 pix_x increments per emitted pixel; pix_addr increments per emitted pixel, never reset by line.
REQ-027 Byte counter == latched word_cnt -> DRAIN; remaining pixels emitted; line_done pulses the cycle after the last pix_valid; pix_y increments with line_done; -> FRAME.
REQ-028 word_cnt mod 5 != 0: err_len set at ls; trailing partial group (1-4 bytes) discarded, no pixels emitted for it.
REQ-029 fe in LINE/DRAIN: pending group discarded, err_trunc set, no line_done, -> IDLE.
REQ-030 fs in FRAME/LINE/DRAIN: err_trunc set if in LINE/DRAIN, frame restarts as REQ-020 (errors then retained, not cleared).
REQ-031 ls in LINE/DRAIN ignored; byte_valid outside LINE ignored.
REQ-032 pix_x, pix_y, pix_addr wrap modulo 2^width silently.

Reset
REQ-033 On reset: state IDLE; pix_valid, line_done, frame_active, err_len, err_trunc = 0; pix_data, pix_x, pix_y, pix_addr, counters, buffers = 0.
REQ-034 Reset mid-line discards all buffered bytes; first output after release requires a new fs.

Structure
REQ-035 Shared CSI package holds FSM state encoding, RAW10 data-type code 6'h2B, group size constant 5.
REQ-036 One sub-module raw10_group_shift: 40-bit group capture plus 4-pixel output shifter.

Verification
REQ-037 fs, ls word_cnt=5, bytes 0x12,0x34,0x56,0x78,0xE4 back-to-back -> pix_data 0x048,0x0D1,0x15A,0x1E3 on 4 consecutive cycles starting 1 cycle after byte 5; line_done next cycle.
REQ-038 fs, 2 lines word_cnt=10 continuous bytes -> 8 pixels/line, pix_x 0..7, pix_y 0 then 1, pix_addr 0..15, no gaps lost.
REQ-039 ls word_cnt=7 -> err_len=1, 4 pixels emitted, 2 trailing bytes dropped, line_done pulses.
REQ-040 fe after 3 bytes of word_cnt=10 line -> err_trunc=1, no pix_valid, no line_done, frame_active=0.
REQ-041 byte_valid toggled 1/0 each cycle, word_cnt=10 -> same 8 pixel values as continuous case.
REQ-042 reset asserted during DRAIN -> all outputs 0 asynchronously; ls without fs afterwards -> no pixels.
